agro_vote_monitor: RTL and testbench
====================================

AGRO_VOTE_MONITOR -- requirements
Module: agro_vote_monitor

Interface
REQ-001 SHALL have parameter N_BITS, default 5, meaning number of sensor input bits (range 1..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning persistence counter width.
REQ-003 SHALL have parameter EVT_W, default 16, meaning alarm event counter width.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port en  input  1  sample/advance enable.
REQ-007 SHALL have port bits  input  N_BITS  raw sensor bits.
REQ-008 SHALL have port thresh  input  $clog2(N_BITS+1)  k-of-N vote threshold.
REQ-009 SHALL have port limit  input  CNT_W  persistence limit, in enabled cycles.
REQ-010 SHALL have port mode  input  1  0 = level alarm, 1 = latched alarm.
REQ-011 SHALL have port clr  input  1  synchronous clear of alarm and persistence state.
REQ-012 SHALL have port vote  output  1  registered vote result.
REQ-013 SHALL have port pcount  output  CNT_W  persistence counter value.
REQ-014 SHALL have port alarm  output  1  registered alarm.
REQ-015 SHALL have port events  output  EVT_W  count of alarm rising edges.

Function
REQ-016 SHALL compute the combinational vote as (popcount(bits) >= thresh); thresh=0 gives 1, thresh>N_BITS gives 0.
REQ-017 SHALL register the vote into vote on each rising edge with en=1, giving 1-cycle latency; vote holds when en=0.
REQ-018 SHALL use limit_eff = max(limit,1).
REQ-019 SHALL, on an en=1 edge with vote=1, set pcount to min(pcount+1, limit_eff).
REQ-020 SHALL, on an en=1 edge with vote=0, set pcount to max(pcount-1, 0), which gives leaky-integrator hysteresis.
REQ-021 SHALL implement FSM states IDLE (pcount=0, alarm=0), ARMING (0<pcount<limit_eff, alarm=0), ALARM (alarm=1, mode=0) and LATCHED (alarm=1, mode=1).
REQ-022 SHALL transition IDLE/ARMING to ALARM (mode=0) or LATCHED (mode=1) on the edge where next pcount reaches limit_eff; alarm goes high on that same edge.
REQ-023 SHALL transition ALARM to IDLE when next pcount is 0; alarm stays high while 0<pcount<=limit_eff.
REQ-024 SHALL hold LATCHED, with alarm=1, regardless of vote or pcount changes, until clr or reset.
REQ-025 SHALL, when clr=1 on an edge, force pcount=0, alarm=0 and state IDLE, independent of en; clr has priority over increment, and vote still updates per REQ-017.
REQ-026 SHALL freeze pcount, state, alarm and events when en=0 and clr=0.
REQ-027 SHALL clamp pcount to limit_eff on the next en=1 edge with vote=1 if limit is lowered below pcount, asserting alarm that edge.
REQ-028 SHALL apply a mode change on the next edge: ALARM with mode=1 goes to LATCHED, and LATCHED with mode=0 goes to ALARM.
REQ-029 SHALL increment events by 1 on each edge where alarm goes 0 to 1, saturating at 2^EVT_W-1; clr does not clear events.
REQ-030 SHALL drive all outputs directly from registers.

Reset
REQ-031 SHALL, while rst=0, asynchronously force vote=0, pcount=0, alarm=0, events=0 and state IDLE.
REQ-032 SHALL abandon any in-progress count on reset mid-operation; operation resumes on the first rising edge after rst returns to 1.

Structure
REQ-033 SHALL take the FSM state enum and default parameter constants (N_BITS=5, CNT_W=8, EVT_W=16) from shared package agro_pkg.
REQ-034 SHALL place the combinational population count and threshold compare in sub-module agro_popcount (parameter N_BITS).

Verification
REQ-035 SHALL cover persistence: N_BITS=5, thresh=3, limit=3, mode=0, en=1, bits=5'b11100 held from edge 1 -> vote=1 after edge 1; pcount 1,2,3 after edges 2,3,4; alarm=1 and events=1 after edge 4.
REQ-036 SHALL cover hysteresis: from REQ-035's end state, bits=5'b00011 -> pcount 2,1,0 on the next edges; alarm falls on the edge pcount becomes 0; events stays 1.
REQ-037 SHALL cover latch and clear: mode=1, alarm reached, then bits=0 for 10 cycles -> alarm stays 1 and pcount reaches 0; clr pulse for 1 cycle -> alarm=0 and state IDLE next edge.
REQ-038 SHALL cover threshold bounds: thresh=0 with bits=0 -> vote=1 after 1 edge; thresh=6 with bits=5'b11111 -> vote=0.
REQ-039 SHALL cover enable, limit and clr priority: en=0 mid-count with pcount=2 -> pcount and alarm frozen for 5 cycles; limit=0 with vote=1 -> alarm after 1 count edge; clr=1 and vote=1 on the same edge -> pcount=0.
REQ-040 SHALL cover reset: rst asserted asynchronously mid-count (pcount=2) between edges -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/agro_pkg.sv
// Shared definitions for the vote monitor slice.
// Provides default parameter values and the alarm FSM state type.
package agro_pkg;

  localparam int unsigned N_BITS_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned EVT_W_DEF  = 16;

  // StIdle: pcount 0, alarm low. StArming: counting up, alarm low.
  // StAlarm: level alarm. StLatched: alarm held until clr or reset.
  typedef enum logic [1:0] {
    StIdle,
    StArming,
    StAlarm,
    StLatched
  } agro_state_e;

endpackage

// File: rtl/agro_vote_monitor_if.sv
// Bundles the control inputs and status outputs of agro_vote_monitor.
// master: drives en/bits/thresh/limit/mode/clr, observes vote/pcount/alarm/events.
// slave:  the monitor itself (reverse directions).
interface agro_vote_monitor_if
  import agro_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned EVT_W  = EVT_W_DEF
) ();

  localparam int unsigned TW = $clog2(N_BITS + 1);

  logic              en;
  logic [N_BITS-1:0] bits;
  logic [TW-1:0]     thresh;
  logic [CNT_W-1:0]  limit;
  logic              mode;
  logic              clr;
  logic              vote;
  logic [CNT_W-1:0]  pcount;
  logic              alarm;
  logic [EVT_W-1:0]  events;

  modport master (
    output en, bits, thresh, limit, mode, clr,
    input  vote, pcount, alarm, events
  );

  modport slave (
    input  en, bits, thresh, limit, mode, clr,
    output vote, pcount, alarm, events
  );

endinterface

// File: rtl/agro_popcount.sv
// Combinational k-of-N vote: vote = (popcount(bits) >= thresh).
// Ports: bits (raw sensor bits), thresh (vote threshold), vote (compare result).
module agro_popcount
  import agro_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEF
) (
  input  logic [N_BITS-1:0]            bits,
  input  logic [$clog2(N_BITS+1)-1:0]  thresh,
  output logic                         vote
);

  localparam int unsigned TW = $clog2(N_BITS + 1);

  logic [TW-1:0] count;

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(N_BITS); i++) begin
      count = count + TW'(bits[i]);
    end
  end

  // thresh == 0 always passes; thresh > N_BITS can never be met.
  assign vote = (count >= thresh);

endmodule

// File: rtl/agro_vote_monitor.sv
// Sensor vote monitor with persistence counting and level/latched alarm.
// Ports: clk, rst (async active-low), bus (slave modport of agro_vote_monitor_if):
//   inputs en, bits, thresh, limit, mode, clr; registered outputs vote, pcount,
//   alarm, events.
// The registered vote (not the raw compare) drives the persistence counter, so a
// change on bits reaches pcount two enabled edges later.
module agro_vote_monitor
  import agro_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned EVT_W  = EVT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  agro_vote_monitor_if.slave  bus
);

  logic             vote_comb;
  logic [CNT_W-1:0] limit_eff;

  logic             vote_q, vote_d;
  logic [CNT_W-1:0] pcount_q, pcount_d;
  logic             alarm_q, alarm_d;
  logic [EVT_W-1:0] events_q, events_d;
  agro_state_e      state_q, state_d;

  agro_popcount #(
    .N_BITS (N_BITS)
  ) u_popcount (
    .bits   (bus.bits),
    .thresh (bus.thresh),
    .vote   (vote_comb)
  );

  assign limit_eff = (bus.limit == '0) ? CNT_W'(1) : bus.limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_q   <= 1'b0;
      pcount_q <= '0;
      alarm_q  <= 1'b0;
      events_q <= '0;
      state_q  <= StIdle;
    end else begin
      vote_q   <= vote_d;
      pcount_q <= pcount_d;
      alarm_q  <= alarm_d;
      events_q <= events_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    vote_d   = bus.en ? vote_comb : vote_q;
    pcount_d = pcount_q;
    state_d  = state_q;
    events_d = events_q;

    if (bus.clr) begin
      pcount_d = '0;
      state_d  = StIdle;
    end else if (bus.en) begin
      // Saturating up/down count; the >= clamp also pulls pcount down when the
      // limit has been lowered below the current count.
      if (vote_q) begin
        pcount_d = (pcount_q >= limit_eff) ? limit_eff : pcount_q + CNT_W'(1);
      end else begin
        pcount_d = (pcount_q == '0) ? '0 : pcount_q - CNT_W'(1);
      end

      unique case (state_q)
        StIdle, StArming: begin
          if (pcount_d >= limit_eff) begin
            state_d = bus.mode ? StLatched : StAlarm;
          end else if (pcount_d == '0) begin
            state_d = StIdle;
          end else begin
            state_d = StArming;
          end
        end
        StAlarm: begin
          if (bus.mode) begin
            state_d = StLatched;
          end else if (pcount_d == '0) begin
            state_d = StIdle;
          end
        end
        StLatched: begin
          if (!bus.mode) begin
            state_d = StAlarm;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    alarm_d = (state_d == StAlarm) || (state_d == StLatched);

    if (alarm_d && !alarm_q && (events_q != '1)) begin
      events_d = events_q + EVT_W'(1);
    end
  end

  assign bus.vote   = vote_q;
  assign bus.pcount = pcount_q;
  assign bus.alarm  = alarm_q;
  assign bus.events = events_q;

endmodule

// File: tb/tb_agro_vote_monitor.sv
// Scoreboard bench for agro_vote_monitor: directed scenarios followed by random
// stimulus, all checked against a behavioural model of the alarm rules.
module tb_agro_vote_monitor;
  import agro_pkg::*;

  localparam int NB = 5;
  localparam int CW = 8;
  localparam int EW = 16;
  localparam int TW = $clog2(NB + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  agro_vote_monitor_if #(.N_BITS(NB), .CNT_W(CW), .EVT_W(EW)) bus ();

  agro_vote_monitor #(
    .N_BITS (NB),
    .CNT_W  (CW),
    .EVT_W  (EW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          v;
    logic [CW-1:0] p;
    logic          a;
    logic [EW-1:0] e;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Model state
  int m_vote, m_p, m_alarm, m_latched, m_events;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_vote = 0; m_p = 0; m_alarm = 0; m_latched = 0; m_events = 0;
  endtask

  // One rising edge of the specified behaviour, computed from current inputs.
  task automatic model_step();
    int le, vc, old_alarm;
    if (!rst) begin
      model_reset();
      return;
    end
    le = (bus.limit == 0) ? 1 : int'(bus.limit);
    vc = ($countones(bus.bits) >= int'(bus.thresh)) ? 1 : 0;
    old_alarm = m_alarm;
    if (bus.clr) begin
      m_p = 0; m_alarm = 0; m_latched = 0;
    end else if (bus.en) begin
      if (m_vote != 0) m_p = (m_p + 1 > le) ? le : m_p + 1;
      else             m_p = (m_p > 0) ? m_p - 1 : 0;
      if (m_alarm == 0) begin
        if (m_p >= le) begin
          m_alarm = 1;
          m_latched = bus.mode ? 1 : 0;
        end
      end else if (m_latched != 0) begin
        if (!bus.mode) m_latched = 0;
      end else if (bus.mode) begin
        m_latched = 1;
      end else if (m_p == 0) begin
        m_alarm = 0;
      end
    end
    if (bus.en) m_vote = vc;
    if (old_alarm == 0 && m_alarm != 0 && m_events < (1 << EW) - 1) m_events++;
  endtask

  // Advance one clock: model the edge, queue the expectation, return at negedge.
  task automatic tick();
    exp_t x;
    @(posedge clk);
    model_step();
    x.v = m_vote[0];
    x.p = CW'(m_p);
    x.a = m_alarm[0];
    x.e = EW'(m_events);
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("sb_vote",   32'(bus.vote),   32'(x.v));
        chk("sb_pcount", 32'(bus.pcount), 32'(x.p));
        chk("sb_alarm",  32'(bus.alarm),  32'(x.a));
        chk("sb_events", 32'(bus.events), 32'(x.e));
      end
    end
  end

  initial begin
    model_reset();
    bus.en = 1'b1; bus.bits = '0; bus.thresh = TW'(3); bus.limit = CW'(3);
    bus.mode = 1'b0; bus.clr = 1'b0;
    @(negedge clk);
    ticks(2);
    chk("reset_pcount", 32'(bus.pcount), 0);
    chk("reset_alarm",  32'(bus.alarm),  0);
    rst = 1'b1;
    ticks(1);

    // Persistence
    bus.bits = 5'b11100;
    ticks(1);
    chk("pers_vote", 32'(bus.vote), 1);
    ticks(3);
    chk("pers_pcount", 32'(bus.pcount), 3);
    chk("pers_alarm",  32'(bus.alarm),  1);
    chk("pers_events", 32'(bus.events), 1);

    // Hysteresis
    bus.bits = 5'b00011;
    ticks(4);
    chk("hyst_pcount", 32'(bus.pcount), 0);
    chk("hyst_alarm",  32'(bus.alarm),  0);
    chk("hyst_events", 32'(bus.events), 1);

    // Latch and clear
    bus.mode = 1'b1; bus.bits = 5'b11100;
    ticks(5);
    bus.bits = '0;
    ticks(10);
    chk("latch_pcount", 32'(bus.pcount), 0);
    chk("latch_alarm",  32'(bus.alarm),  1);
    bus.clr = 1'b1;
    ticks(1);
    bus.clr = 1'b0;
    chk("clr_alarm", 32'(bus.alarm), 0);
    bus.mode = 1'b0;

    // Threshold bounds
    bus.thresh = TW'(0); bus.bits = '0;
    ticks(1);
    chk("thresh0_vote", 32'(bus.vote), 1);
    bus.thresh = TW'(6); bus.bits = 5'b11111;
    ticks(1);
    chk("thresh6_vote", 32'(bus.vote), 0);

    // Enable freeze
    bus.clr = 1'b1; ticks(1); bus.clr = 1'b0;
    bus.thresh = TW'(3); bus.limit = CW'(5); bus.bits = 5'b11100;
    ticks(3);
    chk("en_pre_pcount", 32'(bus.pcount), 2);
    bus.en = 1'b0;
    ticks(5);
    chk("en_frz_pcount", 32'(bus.pcount), 2);
    chk("en_frz_alarm",  32'(bus.alarm),  0);
    bus.en = 1'b1;

    // limit = 0 behaves as 1
    bus.clr = 1'b1; ticks(1); bus.clr = 1'b0;
    bus.limit = '0;
    ticks(1);
    chk("lim0_alarm", 32'(bus.alarm), 1);

    // clr beats increment
    bus.clr = 1'b1; ticks(1); bus.clr = 1'b0;
    chk("clrpri_pcount", 32'(bus.pcount), 0);

    // Limit lowered below pcount clamps and alarms
    bus.limit = CW'(5);
    ticks(3);
    bus.limit = CW'(2);
    ticks(1);
    chk("lower_pcount", 32'(bus.pcount), 2);
    chk("lower_alarm",  32'(bus.alarm),  1);

    // Asynchronous reset mid-count
    bus.clr = 1'b1; ticks(1); bus.clr = 1'b0;
    bus.limit = CW'(5);
    ticks(2);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_vote",   32'(bus.vote),   0);
    chk("arst_pcount", 32'(bus.pcount), 0);
    chk("arst_alarm",  32'(bus.alarm),  0);
    chk("arst_events", 32'(bus.events), 0);
    @(negedge clk);
    ticks(1);
    rst = 1'b1;
    ticks(1);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      bus.bits   = NB'($urandom);
      bus.thresh = TW'($urandom_range(0, 6));
      bus.en     = ($urandom_range(0, 9) < 8);
      bus.clr    = ($urandom_range(0, 39) == 0);
      if (bus.en && $urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
      if (bus.clr) bus.limit = CW'($urandom_range(0, 6));
      tick();
    end

    @(posedge clk);
    #2;
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
